// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: redirect controls, stall/ready handshake and fetch address.
// Optional PC_BRANCH_STATS_EN adds the TakenBranches/Jumps counters.
interface pc_fetch_unit_if #(
    parameter int WIDTH = 32
);
    logic             PCSrc;
    logic [WIDTH-1:0] BranchOffset;
    logic             Jump;
    logic [25:0]      JumpTarget;
    logic             Stall;
    logic             IMemReady;
    logic [WIDTH-1:0] PC;
    logic [WIDTH-1:0] PCPlus4;
    logic             IMemReq;
    logic             InstrValid;
    logic             RedirectPending;
`ifdef PC_BRANCH_STATS_EN
    logic [31:0]      TakenBranches;
    logic [31:0]      Jumps;
`endif

    // The fetch unit drives the fetch address; its environment drives the controls.
    modport master (
        input  PCSrc, BranchOffset, Jump, JumpTarget, Stall, IMemReady,
`ifdef PC_BRANCH_STATS_EN
        output TakenBranches, Jumps,
`endif
        output PC, PCPlus4, IMemReq, InstrValid, RedirectPending
    );

    modport slave (
        output PCSrc, BranchOffset, Jump, JumpTarget, Stall, IMemReady,
`ifdef PC_BRANCH_STATS_EN
        input  TakenBranches, Jumps,
`endif
        input  PC, PCPlus4, IMemReq, InstrValid, RedirectPending
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and next-PC sequencer with a one-entry redirect buffer.
// Define PC_BRANCH_STATS_EN to add saturating taken-branch/jump counters.
module pc_fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    pc_fetch_unit_if.master bus
);
    typedef enum logic [0:0] {
        BOOT  = 1'b0,
        FETCH = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic             pend_q, pend_d;
    logic             pend_jump_q, pend_jump_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] pc_plus4_s;
    logic [WIDTH-1:0] branch_tgt_s;
    logic [WIDTH-1:0] jump_tgt_s;
    logic [WIDTH-1:0] live_tgt_s;
    logic             live_s;
    logic             advance_s;

    // Redirect targets are always computed from the held PC, so a buffered one stays valid.
    always_comb begin
        pc_plus4_s   = pc_q + PC_STEP;
        branch_tgt_s = pc_plus4_s + (bus.BranchOffset << 2);
        jump_tgt_s   = {pc_plus4_s[WIDTH-1:28], bus.JumpTarget, 2'b00};
        live_s       = bus.Jump | bus.PCSrc;
        live_tgt_s   = bus.Jump ? jump_tgt_s : branch_tgt_s;
        advance_s    = (state_q == FETCH) & bus.IMemReady & ~bus.Stall;
    end

    // Next state, next PC and redirect buffer.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        pend_pc_d   = pend_pc_q;
        pend_jump_d = pend_jump_q;
        valid_d     = advance_s;

        case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   state_d = FETCH;
            default: state_d = BOOT;
        endcase

        if (advance_s) begin
            if (live_s) begin
                pc_d = live_tgt_s;
            end else if (pend_q) begin
                pc_d = pend_pc_q;
            end else begin
                pc_d = pc_plus4_s;
            end
            pend_d = 1'b0;
        end else if (live_s) begin
            pend_d      = 1'b1;
            pend_pc_d   = live_tgt_s;
            pend_jump_d = bus.Jump;
        end else begin
            pend_d = pend_q;
        end
    end

    // State, PC and redirect-buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            pend_q      <= 1'b0;
            pend_pc_q   <= '0;
            pend_jump_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pend_pc_q   <= pend_pc_d;
            pend_jump_q <= pend_jump_d;
            valid_q     <= valid_d;
        end
    end

    assign bus.PC              = pc_q;
    assign bus.PCPlus4         = pc_plus4_s;
    assign bus.IMemReq         = (state_q == FETCH);
    assign bus.InstrValid      = valid_q;
    assign bus.RedirectPending = pend_q;

`ifdef PC_BRANCH_STATS_EN
    logic [31:0] taken_q, taken_d;
    logic [31:0] jumps_q, jumps_d;
    logic        applied_jump_s;
    logic        applied_branch_s;

    // A live redirect overrides the buffered one, so its source decides which counter moves.
    always_comb begin
        if (live_s) begin
            applied_jump_s   = advance_s & bus.Jump;
            applied_branch_s = advance_s & ~bus.Jump;
        end else begin
            applied_jump_s   = advance_s & pend_q & pend_jump_q;
            applied_branch_s = advance_s & pend_q & ~pend_jump_q;
        end
        if (applied_branch_s && (taken_q != 32'hFFFF_FFFF)) begin
            taken_d = taken_q + 32'd1;
        end else begin
            taken_d = taken_q;
        end
        if (applied_jump_s && (jumps_q != 32'hFFFF_FFFF)) begin
            jumps_d = jumps_q + 32'd1;
        end else begin
            jumps_d = jumps_q;
        end
    end

    // Statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_q <= 32'd0;
            jumps_q <= 32'd0;
        end else begin
            taken_q <= taken_d;
            jumps_q <= jumps_d;
        end
    end

    assign bus.TakenBranches = taken_q;
    assign bus.Jumps         = jumps_q;
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomised scoreboard bench for pc_fetch_unit against a cycle-level reference model.
module tb_pc_fetch_unit;
    localparam int          W   = 32;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_fetch_unit_if #(.WIDTH(W)) bus ();
    pc_fetch_unit #(.WIDTH(W), .RESET_PC(RPC)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [31:0] pc;
        logic        req;
        logic        pend;
        logic        iv;
        logic [31:0] tb;
        logic [31:0] jp;
    } exp_t;

    exp_t        st_q[$];
    logic [31:0] adv_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    logic [31:0] m_pc = 32'd0, m_ppc = 32'd0, m_tb = 32'd0, m_jp = 32'd0;
    bit          m_boot = 1'b1, m_pend = 1'b0, m_pjump = 1'b0;

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(string name, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat_inc(logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    // Drive one cycle of stimulus and queue what the DUT must show after the next edge.
    task automatic cyc(bit r, bit bsrc, logic [31:0] off, bit j, logic [25:0] jt, bit stall, bit rdy);
        logic [31:0] pc4, tgt;
        bit          live, adv, iv;
        exp_t        e;
        @(negedge clk);
        rst              = r;
        bus.PCSrc        = bsrc;
        bus.BranchOffset = off;
        bus.Jump         = j;
        bus.JumpTarget   = jt;
        bus.Stall        = stall;
        bus.IMemReady    = rdy;
        iv = 1'b0;
        if (r) begin
            m_pc = RPC; m_boot = 1'b1; m_pend = 1'b0; m_tb = 32'd0; m_jp = 32'd0;
        end else begin
            pc4  = m_pc + 32'd4;
            live = j || bsrc;
            tgt  = j ? {pc4[31:28], jt, 2'b00} : pc4 + off * 32'd4;
            adv  = !m_boot && rdy && !stall;
            if (adv) begin
                if (live) begin
                    m_pc = tgt;
                    if (j) m_jp = sat_inc(m_jp);
                    else   m_tb = sat_inc(m_tb);
                end else if (m_pend) begin
                    m_pc = m_ppc;
                    if (m_pjump) m_jp = sat_inc(m_jp);
                    else         m_tb = sat_inc(m_tb);
                end else begin
                    m_pc = pc4;
                end
                m_pend = 1'b0;
                iv = 1'b1;
                adv_q.push_back(m_pc);
            end else if (live) begin
                m_pend = 1'b1; m_ppc = tgt; m_pjump = j;
            end
            m_boot = 1'b0;
        end
        e.pc = m_pc; e.req = !m_boot; e.pend = m_pend; e.iv = iv; e.tb = m_tb; e.jp = m_jp;
        st_q.push_back(e);
    endtask

    task automatic adv_plain();
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 1'b1);
    endtask

    // Branch from the current PC to an arbitrary word-aligned address on an advance cycle.
    task automatic goto(logic [31:0] tgt);
        logic [31:0] off;
        off = (tgt - m_pc - 32'd4) >> 2;
        cyc(1'b0, 1'b1, off, 1'b0, 26'd0, 1'b0, 1'b1);
    endtask

    // Monitor: compares DUT outputs against queued expectations after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.InstrValid === 1'b1) begin
                if (adv_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL adv_unexpected: got InstrValid=1 expected no advance at %0t", $time);
                end else begin
                    check32("adv_pc", bus.PC, adv_q.pop_front());
                end
            end
            if (st_q.size() > 0) begin
                e = st_q.pop_front();
                check32("pc", bus.PC, e.pc);
                check32("pcplus4", bus.PCPlus4, e.pc + 32'd4);
                check1("imemreq", bus.IMemReq, e.req);
                check1("redirect_pending", bus.RedirectPending, e.pend);
                check1("instr_valid", bus.InstrValid, e.iv);
`ifdef PC_BRANCH_STATS_EN
                check32("taken_branches", bus.TakenBranches, e.tb);
                check32("jumps", bus.Jumps, e.jp);
`endif
            end
        end
    end

    // Stimulus: directed scenarios followed by random traffic.
    initial begin
        bus.PCSrc = 1'b0; bus.BranchOffset = 32'd0; bus.Jump = 1'b0;
        bus.JumpTarget = 26'd0; bus.Stall = 1'b0; bus.IMemReady = 1'b0;

        repeat (2) cyc(1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 1'b0);
        // Boot cycle then sequential fetch 0x0, 0x4, 0x8, 0xC, 0x10.
        repeat (5) adv_plain();
        // Branches forward and backward.
        cyc(1'b0, 1'b1, 32'd3, 1'b0, 26'd0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'd0, 1'b0, 1'b1);
        // Jump beats a simultaneous branch.
        goto(32'h3000_4000);
        cyc(1'b0, 1'b1, 32'd5, 1'b1, 26'h0000100, 1'b0, 1'b1);
        // Redirect buffered while memory is not ready.
        goto(32'h0000_0040);
        cyc(1'b0, 1'b1, 32'd4, 1'b0, 26'd0, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 1'b0);
        adv_plain();
        // Pending redirect under stall, discarded by reset.
        cyc(1'b0, 1'b1, 32'd8, 1'b0, 26'd0, 1'b1, 1'b1);
        repeat (2) cyc(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 1'b1);
        repeat (3) adv_plain();
        // Buffered jump, overwritten by a newer buffered branch, and a buffered jump applied.
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 26'h0000200, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 32'd6, 1'b0, 26'd0, 1'b0, 1'b0);
        adv_plain();
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 26'h0000300, 1'b1, 1'b0);
        adv_plain();
        // Address wrap.
        goto(32'hFFFF_FFFC);
        repeat (2) adv_plain();

        repeat (400) begin
            logic [31:0] off;
            off = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed($urandom_range(0, 32)) - 16);
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0), off,
                ($urandom_range(0, 5) == 0), 26'($urandom),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
        end
        repeat (2) cyc(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 1'b0);

        @(posedge clk);
        #2;
        n_cmp++;
        if (st_q.size() != 0 || adv_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d/%0d entries left expected 0/0", st_q.size(), adv_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and next-PC sequencer.
- Sits directly downstream of the branch-decision gate: consumes PCSrc (Branch AND Zero) plus the jump controls, and drives the instruction-memory fetch address.
- Handshakes with instruction memory (request/ready) and honours pipeline stalls.
- Buffers a branch or jump redirect that arrives while a fetch is pending, so the redirect is never lost.

Parameters:
- WIDTH, 32, PC/address width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- PCSrc  input  1  branch taken, from the Branch/Zero AND gate.
- BranchOffset  input  WIDTH  sign-extended word offset from the immediate.
- Jump  input  1  unconditional jump.
- JumpTarget  input  26  instruction jump field.
- Stall  input  1  hold the PC; pipeline is not ready.
- IMemReady  input  1  instruction memory accepts/returns the current fetch.
- PC  output  WIDTH  current fetch address.
- PCPlus4  output  WIDTH  PC + 4, combinational.
- IMemReq  output  1  fetch request.
- InstrValid  output  1  one-cycle pulse: the instruction at PC has been consumed.
- RedirectPending  output  1  a buffered redirect is waiting.

Behaviour:
- Reset is synchronous, active-high; clk and rst are the only clock and reset.
- Reset values: PC=RESET_PC, IMemReq=0, InstrValid=0, RedirectPending=0, state=BOOT.
- A reset that arrives mid-wait discards any pending redirect.
- FSM states:
  - BOOT: IMemReq=0 for exactly one cycle after rst deasserts, then go to FETCH.
  - FETCH: IMemReq=1. Stays in FETCH; rst returns the FSM to BOOT.
- Advance = state==FETCH & IMemReady & ~Stall. InstrValid = Advance, registered: it pulses in the cycle after Advance.
- Target arithmetic (all results modulo 2^WIDTH, wrap-around silently):
  - BranchTarget = PCPlus4 + (BranchOffset << 2).
  - JumpAddr = {PCPlus4[WIDTH-1:28], JumpTarget, 2'b00}.
- Live redirect priority: Jump > PCSrc. A live redirect is Jump or PCSrc asserted in the current cycle.
- On Advance, PC is loaded with:
  - the live redirect target, if any; else
  - PendingPC, if RedirectPending=1; else
  - PCPlus4.
- RedirectPending clears on Advance.
- Live redirect on a non-Advance cycle (stalled, not ready, or in BOOT): the target is latched into PendingPC and RedirectPending is set. A newer redirect overwrites an older pending one.
- PC is unchanged on every non-Advance cycle, so a buffered target stays correct.
- Simultaneous Jump and PCSrc: Jump wins for both the live and the latched path.
- Stall and IMemReady together: no advance. IMemReq stays high; the memory must hold its data.
- Latency: redirect on an Advance cycle → new PC visible on the next clk edge (1 cycle).

Optional Feature:
- Macro: PC_BRANCH_STATS_EN.
- When defined:
  - Adds outputs TakenBranches[31:0] and Jumps[31:0].
  - Each counter increments once per Advance that applies a PCSrc-sourced (resp. Jump-sourced) target, whether live or pending.
  - Counters saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
1. Reset, then IMemReady=1, Stall=0 for 4 cycles → IMemReq=0 for 1 cycle after reset; PC sequence 0x0, 0x4, 0x8, 0xC; InstrValid pulses each cycle.
2. PC=0x10, PCSrc=1, BranchOffset=3 on an Advance cycle → PC=0x20 next cycle. Then PCSrc=1, BranchOffset=-2 (0xFFFFFFFE) → PC=0x1C.
3. PC=0x30004000, Jump=1, JumpTarget=26'h0000100, PCSrc=1 simultaneously → PC=0x30000400; with PC_BRANCH_STATS_EN, Jumps increments and TakenBranches does not.
4. PC=0x40, IMemReady=0, PCSrc pulses with BranchOffset=4 → RedirectPending=1, PC holds at 0x40. Later IMemReady=1 → PC=0x54, RedirectPending=0.
5. Stall=1 with a pending redirect for 3 cycles, then rst=1 → PC=RESET_PC, RedirectPending=0, IMemReq=0. After release, fetch restarts at 0x0.
6. PC=0xFFFFFFFC, IMemReady=1 → PCPlus4=0x0 and PC wraps to 0x0.
